// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Bundles the fetch-side inputs, the downstream stall/flush controls and the
// ID/EX pipeline-register outputs of the instruction-decode stage.
//   slave  : decode stage side (id_stage)
//   master : surrounding pipeline / testbench side
// Signals:
//   if_valid_ip, if_instr_ip, if_pc_ip   fetched instruction and its PC
//   ex_stall_ip, flush_ip                EX back-pressure, branch flush
//   id_stall_op                          IF must hold its instruction/PC
//   rd_port1_op, rd_port2_op             register-file read addresses
//   ex_*_op                              ID/EX register contents
// -----------------------------------------------------------------------------
interface id_stage_if;
  logic        if_valid_ip;
  logic [31:0] if_instr_ip;
  logic [31:0] if_pc_ip;
  logic        ex_stall_ip;
  logic        flush_ip;
  logic        id_stall_op;
  logic [4:0]  rd_port1_op;
  logic [4:0]  rd_port2_op;
  logic        ex_valid_op;
  logic [31:0] ex_pc_op;
  logic [31:0] ex_imm_op;
  logic [4:0]  ex_rd_op;
  logic [4:0]  ex_rs1_op;
  logic [4:0]  ex_rs2_op;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_op;
  logic        ex_mem_rd_op;
  logic        ex_mem_wr_op;
  logic        ex_reg_wr_op;
  logic        ex_branch_op;
  logic        ex_jump_op;
  logic        ex_illegal_op;

  modport master (
    output if_valid_ip, if_instr_ip, if_pc_ip, ex_stall_ip, flush_ip,
    input  id_stall_op, rd_port1_op, rd_port2_op,
    input  ex_valid_op, ex_pc_op, ex_imm_op, ex_rd_op, ex_rs1_op, ex_rs2_op,
    input  ex_alu_op, ex_alu_src_op, ex_mem_rd_op, ex_mem_wr_op,
    input  ex_reg_wr_op, ex_branch_op, ex_jump_op, ex_illegal_op
  );

  modport slave (
    input  if_valid_ip, if_instr_ip, if_pc_ip, ex_stall_ip, flush_ip,
    output id_stall_op, rd_port1_op, rd_port2_op,
    output ex_valid_op, ex_pc_op, ex_imm_op, ex_rd_op, ex_rs1_op, ex_rs2_op,
    output ex_alu_op, ex_alu_src_op, ex_mem_rd_op, ex_mem_wr_op,
    output ex_reg_wr_op, ex_branch_op, ex_jump_op, ex_illegal_op
  );
endinterface

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Instruction-decode stage of the five-stage RV32I core. Drives register-file
// read addresses straight from the fetched instruction, decodes immediate,
// ALU and control fields, and captures them in the ID/EX register. Handles
// downstream stall, branch flush and (optionally) load-use bubbles.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset (clears the whole ID/EX register)
//   bus    id_stage_if.slave: fetch inputs, stall/flush, ID/EX outputs
// Configuration:
//   ID_HAZARD_DETECT_EN  when defined, load-use hazards insert one bubble and
//                        stall fetch; when undefined the toolchain guarantees
//                        no load-use adjacency and hazard is tied low.
// -----------------------------------------------------------------------------
module id_stage (
  input  logic      clk,
  input  logic      rst_n,
  id_stage_if.slave bus
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic        alu_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
  } idex_t;

  localparam idex_t IDEX_ZERO = idex_t'({$bits(idex_t){1'b0}});

  // Instruction fields
  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        alt_s;
  logic [4:0]  rd_idx_s;
  logic [4:0]  rs1_idx_s;
  logic [4:0]  rs2_idx_s;

  assign instr_s   = bus.if_instr_ip;
  assign opcode_s  = instr_s[6:0];
  assign rd_idx_s  = instr_s[11:7];
  assign funct3_s  = instr_s[14:12];
  assign rs1_idx_s = instr_s[19:15];
  assign rs2_idx_s = instr_s[24:20];
  assign alt_s     = instr_s[30];

  // Register-file addresses are raw fields so the read overlaps decode.
  assign bus.rd_port1_op = rs1_idx_s;
  assign bus.rd_port2_op = rs2_idx_s;

  // Immediates, all sign-extended from instr[31]
  logic [31:0] imm_i_s;
  logic [31:0] imm_st_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_st_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s  = {{20{instr_s[31]}}, instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s  = {instr_s[31:12], 12'h000};
  assign imm_j_s  = {{12{instr_s[31]}}, instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

  // ALU operation from funct3 shared by R and I-ALU; SUB is R-only and added later
  logic [3:0] alu_f3_s;

  // Map funct3 onto the ALU encoding, instr[30] choosing arithmetic right shift
  always_comb begin
    alu_f3_s = ALU_ADD;
    case (funct3_s)
      3'b000:  alu_f3_s = ALU_ADD;
      3'b001:  alu_f3_s = ALU_SLL;
      3'b010:  alu_f3_s = ALU_SLT;
      3'b011:  alu_f3_s = ALU_SLTU;
      3'b100:  alu_f3_s = ALU_XOR;
      3'b101: begin
        if (alt_s) begin
          alu_f3_s = ALU_SRA;
        end else begin
          alu_f3_s = ALU_SRL;
        end
      end
      3'b110:  alu_f3_s = ALU_OR;
      3'b111:  alu_f3_s = ALU_AND;
      default: alu_f3_s = ALU_ADD;
    endcase
  end

  logic [31:0] imm_s;
  logic [3:0]  alu_s;
  logic        alu_src_s;
  logic        mem_rd_s;
  logic        mem_wr_s;
  logic        reg_wr_s;
  logic        branch_s;
  logic        jump_s;
  logic        illegal_s;
  logic        use_rs1_s;
  logic        use_rs2_s;

  // Main opcode decode into immediate, ALU and control fields
  always_comb begin
    imm_s     = 32'h0000_0000;
    alu_s     = ALU_ADD;
    alu_src_s = 1'b0;
    mem_rd_s  = 1'b0;
    mem_wr_s  = 1'b0;
    reg_wr_s  = 1'b0;
    branch_s  = 1'b0;
    jump_s    = 1'b0;
    illegal_s = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    case (opcode_s)
      OPC_R: begin
        if ((funct3_s == 3'b000) && alt_s) begin
          alu_s = ALU_SUB;
        end else begin
          alu_s = alu_f3_s;
        end
        reg_wr_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OPC_I_ALU: begin
        imm_s     = imm_i_s;
        alu_s     = alu_f3_s;
        alu_src_s = 1'b1;
        reg_wr_s  = 1'b1;
        use_rs1_s = 1'b1;
      end
      OPC_LOAD: begin
        imm_s     = imm_i_s;
        alu_src_s = 1'b1;
        mem_rd_s  = 1'b1;
        reg_wr_s  = 1'b1;
        use_rs1_s = 1'b1;
      end
      OPC_STORE: begin
        imm_s     = imm_st_s;
        alu_src_s = 1'b1;
        mem_wr_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OPC_BRANCH: begin
        // EX compares rs1 against rs2; the target adder uses the immediate
        imm_s     = imm_b_s;
        alu_s     = ALU_SUB;
        branch_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OPC_JAL: begin
        imm_s     = imm_j_s;
        alu_src_s = 1'b1;
        reg_wr_s  = 1'b1;
        jump_s    = 1'b1;
      end
      OPC_JALR: begin
        imm_s     = imm_i_s;
        alu_src_s = 1'b1;
        reg_wr_s  = 1'b1;
        jump_s    = 1'b1;
        use_rs1_s = 1'b1;
      end
      OPC_LUI: begin
        imm_s     = imm_u_s;
        alu_s     = ALU_PASSB;
        alu_src_s = 1'b1;
        reg_wr_s  = 1'b1;
      end
      OPC_AUIPC: begin
        imm_s     = imm_u_s;
        alu_src_s = 1'b1;
        reg_wr_s  = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  idex_t idex_r;
  logic  hazard_s;

`ifdef ID_HAZARD_DETECT_EN
  // Load in EX whose destination is a source actually read by the instruction in ID
  assign hazard_s = idex_r.valid & idex_r.mem_rd & (idex_r.rd != 5'd0) & bus.if_valid_ip &
                    ((use_rs1_s & (rs1_idx_s == idex_r.rd)) |
                     (use_rs2_s & (rs2_idx_s == idex_r.rd)));
`else
  assign hazard_s = 1'b0;
`endif

  assign bus.id_stall_op = ~bus.flush_ip & (bus.ex_stall_ip | hazard_s);

  // Flush overrides the EX hold; otherwise a stall freezes the register
  logic  load_en_s;
  idex_t idex_nxt_s;

  assign load_en_s = bus.flush_ip | ~bus.ex_stall_ip;

  // Next ID/EX contents: a zero bubble on flush/hazard, else the gated decode
  always_comb begin
    idex_nxt_s = IDEX_ZERO;
    if (bus.flush_ip || hazard_s) begin
      idex_nxt_s = IDEX_ZERO;
    end else begin
      idex_nxt_s.valid   = bus.if_valid_ip;
      idex_nxt_s.pc      = bus.if_pc_ip;
      idex_nxt_s.imm     = imm_s;
      // Unused indices are zeroed so forwarding never matches a stale field
      idex_nxt_s.rd      = reg_wr_s  ? rd_idx_s  : 5'd0;
      idex_nxt_s.rs1     = use_rs1_s ? rs1_idx_s : 5'd0;
      idex_nxt_s.rs2     = use_rs2_s ? rs2_idx_s : 5'd0;
      idex_nxt_s.alu     = alu_s;
      idex_nxt_s.alu_src = alu_src_s;
      idex_nxt_s.mem_rd  = mem_rd_s  & bus.if_valid_ip;
      idex_nxt_s.mem_wr  = mem_wr_s  & bus.if_valid_ip;
      idex_nxt_s.reg_wr  = reg_wr_s  & bus.if_valid_ip;
      idex_nxt_s.branch  = branch_s  & bus.if_valid_ip;
      idex_nxt_s.jump    = jump_s    & bus.if_valid_ip;
      idex_nxt_s.illegal = illegal_s & bus.if_valid_ip;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_r <= IDEX_ZERO;
    end else if (load_en_s) begin
      idex_r <= idex_nxt_s;
    end
  end

  assign bus.ex_valid_op   = idex_r.valid;
  assign bus.ex_pc_op      = idex_r.pc;
  assign bus.ex_imm_op     = idex_r.imm;
  assign bus.ex_rd_op      = idex_r.rd;
  assign bus.ex_rs1_op     = idex_r.rs1;
  assign bus.ex_rs2_op     = idex_r.rs2;
  assign bus.ex_alu_op     = idex_r.alu;
  assign bus.ex_alu_src_op = idex_r.alu_src;
  assign bus.ex_mem_rd_op  = idex_r.mem_rd;
  assign bus.ex_mem_wr_op  = idex_r.mem_wr;
  assign bus.ex_reg_wr_op  = idex_r.reg_wr;
  assign bus.ex_branch_op  = idex_r.branch;
  assign bus.ex_jump_op    = idex_r.jump;
  assign bus.ex_illegal_op = idex_r.illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Self-checking bench for id_stage. Directed scenarios from the decode stage's
// behaviour plus a randomized run checked against a reference model that
// decodes instructions arithmetically and tracks the expected ID/EX contents.
// Works with ID_HAZARD_DETECT_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic clk;
  logic rst_n;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] I_ADDI = 32'h0050_0093; // ADDI x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0000_A103; // LW   x2,0(x1)
  localparam logic [31:0] I_ADD  = 32'h0021_01B3; // ADD  x3,x2,x2
  localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3; // BEQ  x0,x0,-4

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic        alu_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic        imm_c;
    logic        alu_c;
    logic        src_c;
    logic        use1;
    logic        use2;
  } exp_t;

  exp_t exp_r;

  logic [3:0] f3_alu [0:7];
  initial begin
    f3_alu[0] = 4'd0; f3_alu[1] = 4'd2; f3_alu[2] = 4'd3; f3_alu[3] = 4'd4;
    f3_alu[4] = 4'd5; f3_alu[5] = 4'd6; f3_alu[6] = 4'd8; f3_alu[7] = 4'd9;
  end

  // Reference decode: what EX should see for this instruction
  function automatic exp_t m_decode(logic [31:0] instr, logic [31:0] pc, logic v);
    exp_t        e;
    logic [31:0] sx;
    logic [31:0] ii;
    logic [31:0] hi7;
    int          f3;
    bit          alt;
    e   = '0;
    sx  = $signed(instr) >>> 31;
    ii  = $signed(instr) >>> 20;
    hi7 = $signed(instr) >>> 25;
    f3  = int'(instr[14:12]);
    alt = instr[30];
    case (instr[6:0])
      7'h33: begin
        e.alu = f3_alu[f3];
        if (alt && f3 == 0) e.alu = 4'd1;
        if (alt && f3 == 5) e.alu = 4'd7;
        e.alu_c = 1'b1; e.src_c = 1'b1; e.alu_src = 1'b0;
        e.reg_wr = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1;
      end
      7'h13: begin
        e.alu = f3_alu[f3];
        if (alt && f3 == 5) e.alu = 4'd7;
        e.imm = ii; e.imm_c = 1'b1; e.alu_c = 1'b1; e.src_c = 1'b1; e.alu_src = 1'b1;
        e.reg_wr = 1'b1; e.use1 = 1'b1;
      end
      7'h03: begin
        e.imm = ii; e.imm_c = 1'b1; e.alu_c = 1'b1; e.src_c = 1'b1; e.alu_src = 1'b1;
        e.mem_rd = 1'b1; e.reg_wr = 1'b1; e.use1 = 1'b1;
      end
      7'h23: begin
        e.imm = (hi7 << 5) | 32'(instr[11:7]);
        e.imm_c = 1'b1; e.alu_c = 1'b1; e.src_c = 1'b1; e.alu_src = 1'b1;
        e.mem_wr = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1;
      end
      7'h63: begin
        e.imm = (sx << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5) | (32'(instr[11:8]) << 1);
        e.imm_c = 1'b1; e.branch = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1;
      end
      7'h6F: begin
        e.imm = (sx << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11) | (32'(instr[30:21]) << 1);
        e.imm_c = 1'b1; e.alu_c = 1'b1; e.jump = 1'b1; e.reg_wr = 1'b1;
      end
      7'h67: begin
        e.imm = ii; e.imm_c = 1'b1; e.alu_c = 1'b1;
        e.jump = 1'b1; e.reg_wr = 1'b1; e.use1 = 1'b1;
      end
      7'h37: begin
        e.imm = instr & 32'hFFFF_F000; e.imm_c = 1'b1;
        e.alu = 4'd10; e.alu_c = 1'b1; e.alu_src = 1'b1; e.src_c = 1'b1; e.reg_wr = 1'b1;
      end
      7'h17: begin
        e.imm = instr & 32'hFFFF_F000; e.imm_c = 1'b1;
        e.alu_c = 1'b1; e.alu_src = 1'b1; e.src_c = 1'b1; e.reg_wr = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    e.rd  = e.reg_wr ? instr[11:7]  : 5'd0;
    e.rs1 = e.use1   ? instr[19:15] : 5'd0;
    e.rs2 = e.use2   ? instr[24:20] : 5'd0;
    e.pc    = pc;
    e.valid = v;
    if (!v) begin
      e.mem_rd = 1'b0; e.mem_wr = 1'b0; e.reg_wr = 1'b0;
      e.branch = 1'b0; e.jump = 1'b0; e.illegal = 1'b0;
    end
    return e;
  endfunction

  // Load in EX feeding a source register read by the instruction in ID
  function automatic bit m_hazard(exp_t st, logic v, logic [31:0] instr);
    exp_t d;
    d = m_decode(instr, 32'd0, 1'b1);
`ifdef ID_HAZARD_DETECT_EN
    return st.valid && st.mem_rd && (st.rd != 5'd0) && v &&
           ((d.use1 && instr[19:15] == st.rd) || (d.use2 && instr[24:20] == st.rd));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_stall();
    return !bus.flush_ip && (bus.ex_stall_ip || m_hazard(exp_r, bus.if_valid_ip, bus.if_instr_ip));
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:       w[6:0] = 7'h33;
      1:       w[6:0] = 7'h13;
      2, 3, 4: w[6:0] = 7'h03;
      5:       w[6:0] = 7'h23;
      6:       w[6:0] = 7'h63;
      7:       w[6:0] = 7'h6F;
      8:       w[6:0] = 7'h67;
      9:       w[6:0] = 7'h37;
      10:      w[6:0] = 7'h17;
      default: w[6:0] = 7'($urandom);
    endcase
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  // Apply inputs away from the clock edge and let combinational outputs settle
  task automatic drive(logic v, logic [31:0] instr, logic [31:0] pc, logic st, logic fl);
    bus.if_valid_ip = v;
    bus.if_instr_ip = instr;
    bus.if_pc_ip    = pc;
    bus.ex_stall_ip = st;
    bus.flush_ip    = fl;
    #1;
  endtask

  // Advance the model by one edge, then the DUT, sampling 1 time unit later
  task automatic tick();
    if (!rst_n)                                                         exp_r = '0;
    else if (bus.flush_ip)                                              exp_r = '0;
    else if (bus.ex_stall_ip)                                           exp_r = exp_r;
    else if (m_hazard(exp_r, bus.if_valid_ip, bus.if_instr_ip))         exp_r = '0;
    else exp_r = m_decode(bus.if_instr_ip, bus.if_pc_ip, bus.if_valid_ip);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, I_ADDI, 32'h0000_0100, 1'b0, 1'b0);
    tick();
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.ex_valid_op); end
    n_tests++; if ({bus.ex_reg_wr_op, bus.ex_mem_rd_op, bus.ex_mem_wr_op, bus.ex_branch_op, bus.ex_jump_op, bus.ex_illegal_op} !== 6'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got nonzero control bits"); end
    n_tests++; if (bus.ex_pc_op !== 32'd0 || bus.ex_imm_op !== 32'd0) begin n_fail++; $display("FAIL reset_data: pc %h imm %h want 0", bus.ex_pc_op, bus.ex_imm_op); end
    n_tests++; if (bus.id_stall_op !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.id_stall_op); end
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", bus.ex_valid_op); end
    n_tests++; if (bus.ex_rd_op !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", bus.ex_rd_op); end
    n_tests++; if (bus.ex_imm_op !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", bus.ex_imm_op); end
    n_tests++; if (bus.ex_alu_op !== 4'd0 || bus.ex_alu_src_op !== 1'b1) begin n_fail++; $display("FAIL addi_alu: got op %0d src %b want 0/1", bus.ex_alu_op, bus.ex_alu_src_op); end
    n_tests++; if (bus.ex_reg_wr_op !== 1'b1 || bus.ex_pc_op !== 32'h100) begin n_fail++; $display("FAIL addi_wr_pc: got wr %b pc %h want 1/100", bus.ex_reg_wr_op, bus.ex_pc_op); end
  endtask

  task automatic test_load_use();
    drive(1'b1, I_LW, 32'h0000_0200, 1'b0, 1'b0);
    tick();
    n_tests++; if (bus.ex_mem_rd_op !== 1'b1 || bus.ex_rd_op !== 5'd2) begin n_fail++; $display("FAIL lw_fields: got mem_rd %b rd %0d want 1/2", bus.ex_mem_rd_op, bus.ex_rd_op); end
    drive(1'b1, I_ADD, 32'h0000_0204, 1'b0, 1'b0);
    n_tests++; if (bus.rd_port1_op !== 5'd2 || bus.rd_port2_op !== 5'd2) begin n_fail++; $display("FAIL add_ports: got %0d/%0d want 2/2", bus.rd_port1_op, bus.rd_port2_op); end
`ifdef ID_HAZARD_DETECT_EN
    n_tests++; if (bus.id_stall_op !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", bus.id_stall_op); end
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b0 || bus.ex_mem_rd_op !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got valid %b mem_rd %b want 0/0", bus.ex_valid_op, bus.ex_mem_rd_op); end
    drive(1'b1, I_ADD, 32'h0000_0204, 1'b0, 1'b0);
    n_tests++; if (bus.id_stall_op !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", bus.id_stall_op); end
    tick();
`else
    n_tests++; if (bus.id_stall_op !== 1'b0) begin n_fail++; $display("FAIL lu_nostall: got %b want 0", bus.id_stall_op); end
    tick();
`endif
    n_tests++; if (bus.ex_valid_op !== 1'b1 || bus.ex_pc_op !== 32'h204) begin n_fail++; $display("FAIL add_valid: got valid %b pc %h want 1/204", bus.ex_valid_op, bus.ex_pc_op); end
    n_tests++; if (bus.ex_rs1_op !== 5'd2 || bus.ex_rs2_op !== 5'd2 || bus.ex_rd_op !== 5'd3) begin n_fail++; $display("FAIL add_regs: got %0d/%0d/%0d want 2/2/3", bus.ex_rs1_op, bus.ex_rs2_op, bus.ex_rd_op); end
    n_tests++; if (bus.ex_alu_op !== 4'd0 || bus.ex_alu_src_op !== 1'b0) begin n_fail++; $display("FAIL add_alu: got %0d/%b want 0/0", bus.ex_alu_op, bus.ex_alu_src_op); end
  endtask

  task automatic test_hazard_with_stall();
    drive(1'b1, I_LW, 32'h0000_0600, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_ADD, 32'h0000_0604, 1'b1, 1'b0);
    n_tests++; if (bus.id_stall_op !== 1'b1) begin n_fail++; $display("FAIL hs_stall: got %b want 1", bus.id_stall_op); end
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b1 || bus.ex_mem_rd_op !== 1'b1 || bus.ex_pc_op !== 32'h600)
      begin n_fail++; $display("FAIL hs_hold: got valid %b mem_rd %b pc %h want 1/1/600", bus.ex_valid_op, bus.ex_mem_rd_op, bus.ex_pc_op); end
    drive(1'b1, I_ADD, 32'h0000_0604, 1'b0, 1'b0);
    tick();
`ifdef ID_HAZARD_DETECT_EN
    n_tests++; if (bus.ex_valid_op !== 1'b0) begin n_fail++; $display("FAIL hs_bubble: got %b want 0", bus.ex_valid_op); end
`else
    n_tests++; if (bus.ex_valid_op !== 1'b1 || bus.ex_pc_op !== 32'h604) begin n_fail++; $display("FAIL hs_add: got %b pc %h want 1/604", bus.ex_valid_op, bus.ex_pc_op); end
`endif
  endtask

  task automatic test_branch();
    drive(1'b1, I_BEQ, 32'h0000_0300, 1'b0, 1'b0);
    tick();
    n_tests++; if (bus.ex_imm_op !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL beq_imm: got %h want fffffffc", bus.ex_imm_op); end
    n_tests++; if (bus.ex_branch_op !== 1'b1 || bus.ex_reg_wr_op !== 1'b0 || bus.ex_jump_op !== 1'b0)
      begin n_fail++; $display("FAIL beq_ctrl: got br %b wr %b jmp %b want 1/0/0", bus.ex_branch_op, bus.ex_reg_wr_op, bus.ex_jump_op); end
  endtask

  task automatic test_stall();
    drive(1'b1, I_ADDI, 32'h0000_0400, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, gen_instr(), 32'h0000_0404 + 32'(4 * i), 1'b1, 1'b0);
      n_tests++; if (bus.id_stall_op !== 1'b1) begin n_fail++; $display("FAIL stall_out[%0d]: got %b want 1", i, bus.id_stall_op); end
      tick();
      n_tests++;
      if (bus.ex_valid_op !== 1'b1 || bus.ex_pc_op !== 32'h400 || bus.ex_imm_op !== 32'd5 ||
          bus.ex_rd_op !== 5'd1 || bus.ex_reg_wr_op !== 1'b1 || bus.ex_alu_src_op !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got valid %b pc %h imm %h rd %0d want 1/400/5/1", i, bus.ex_valid_op, bus.ex_pc_op, bus.ex_imm_op, bus.ex_rd_op); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, I_ADDI, 32'h0000_0500, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_BEQ, 32'h0000_0504, 1'b1, 1'b1);
    n_tests++; if (bus.id_stall_op !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.id_stall_op); end
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b0 || bus.ex_reg_wr_op !== 1'b0 || bus.ex_branch_op !== 1'b0)
      begin n_fail++; $display("FAIL flush_valid: got valid %b wr %b br %b want 0", bus.ex_valid_op, bus.ex_reg_wr_op, bus.ex_branch_op); end
    drive(1'b1, I_LW, 32'h0000_0508, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_ADD, 32'h0000_050C, 1'b0, 1'b1);
    n_tests++; if (bus.id_stall_op !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_stall: got %b want 0", bus.id_stall_op); end
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b0 || bus.ex_mem_rd_op !== 1'b0) begin n_fail++; $display("FAIL flush_load: got %b/%b want 0/0", bus.ex_valid_op, bus.ex_mem_rd_op); end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'h7F;
    drive(1'b1, w, 32'h0000_0700, 1'b0, 1'b0);
    tick();
    n_tests++; if (bus.ex_illegal_op !== 1'b1 || bus.ex_valid_op !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got ill %b valid %b want 1/1", bus.ex_illegal_op, bus.ex_valid_op); end
    n_tests++; if ({bus.ex_reg_wr_op, bus.ex_mem_wr_op, bus.ex_mem_rd_op, bus.ex_branch_op, bus.ex_jump_op} !== 5'b0)
      begin n_fail++; $display("FAIL illegal_ctrl: got wr %b mwr %b mrd %b br %b j %b want 0", bus.ex_reg_wr_op, bus.ex_mem_wr_op, bus.ex_mem_rd_op, bus.ex_branch_op, bus.ex_jump_op); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      w = gen_instr();
      drive(($urandom_range(0, 99) < 85), w, 32'($urandom) & 32'hFFFF_FFFC,
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
      n_tests++; if (bus.id_stall_op !== m_stall()) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b instr %h", i, bus.id_stall_op, m_stall(), w); end
      n_tests++; if (bus.rd_port1_op !== w[19:15] || bus.rd_port2_op !== w[24:20]) begin n_fail++; $display("FAIL rnd_ports[%0d]: got %0d/%0d instr %h", i, bus.rd_port1_op, bus.rd_port2_op, w); end
      tick();
      n_tests++; if (bus.ex_valid_op !== exp_r.valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.ex_valid_op, exp_r.valid); end
      n_tests++;
      if ({bus.ex_mem_rd_op, bus.ex_mem_wr_op, bus.ex_reg_wr_op, bus.ex_branch_op, bus.ex_jump_op, bus.ex_illegal_op} !==
          {exp_r.mem_rd, exp_r.mem_wr, exp_r.reg_wr, exp_r.branch, exp_r.jump, exp_r.illegal})
        begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b%b%b%b%b%b want %b%b%b%b%b%b", i,
          bus.ex_mem_rd_op, bus.ex_mem_wr_op, bus.ex_reg_wr_op, bus.ex_branch_op, bus.ex_jump_op, bus.ex_illegal_op,
          exp_r.mem_rd, exp_r.mem_wr, exp_r.reg_wr, exp_r.branch, exp_r.jump, exp_r.illegal); end
      if (exp_r.valid) begin
        n_tests++; if (bus.ex_pc_op !== exp_r.pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.ex_pc_op, exp_r.pc); end
        if (exp_r.imm_c) begin
          n_tests++; if (bus.ex_imm_op !== exp_r.imm) begin n_fail++; $display("FAIL rnd_imm[%0d]: got %h want %h", i, bus.ex_imm_op, exp_r.imm); end
        end
        if (exp_r.reg_wr) begin
          n_tests++; if (bus.ex_rd_op !== exp_r.rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %0d want %0d", i, bus.ex_rd_op, exp_r.rd); end
        end
        if (exp_r.use1) begin
          n_tests++; if (bus.ex_rs1_op !== exp_r.rs1) begin n_fail++; $display("FAIL rnd_rs1[%0d]: got %0d want %0d", i, bus.ex_rs1_op, exp_r.rs1); end
        end
        if (exp_r.use2) begin
          n_tests++; if (bus.ex_rs2_op !== exp_r.rs2) begin n_fail++; $display("FAIL rnd_rs2[%0d]: got %0d want %0d", i, bus.ex_rs2_op, exp_r.rs2); end
        end
        if (exp_r.alu_c) begin
          n_tests++; if (bus.ex_alu_op !== exp_r.alu) begin n_fail++; $display("FAIL rnd_alu[%0d]: got %0d want %0d", i, bus.ex_alu_op, exp_r.alu); end
        end
        if (exp_r.src_c) begin
          n_tests++; if (bus.ex_alu_src_op !== exp_r.alu_src) begin n_fail++; $display("FAIL rnd_src[%0d]: got %b want %b", i, bus.ex_alu_src_op, exp_r.alu_src); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, I_ADDI, 32'h0000_0800, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    exp_r = '0;
    n_tests++; if (bus.ex_valid_op !== 1'b0 || bus.ex_reg_wr_op !== 1'b0 || bus.ex_pc_op !== 32'd0)
      begin n_fail++; $display("FAIL async_reset: got valid %b wr %b pc %h want 0", bus.ex_valid_op, bus.ex_reg_wr_op, bus.ex_pc_op); end
    rst_n = 1'b1;
    drive(1'b0, I_ADDI, 32'h0000_0804, 1'b0, 1'b0);
    tick();
    n_tests++; if (bus.ex_valid_op !== 1'b0) begin n_fail++; $display("FAIL after_reset_idle: got %b want 0", bus.ex_valid_op); end
  endtask

  initial begin
    rst_n = 1'b0;
    exp_r = '0;
    test_reset();
    test_load_use();
    test_hazard_with_stall();
    test_branch();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
